// File: rtl/regfile_pkg.sv
// Shared constants and types for the parametrised register file with busy-bit scoreboard.
// No logic of its own; popcount_busy exists only for the scoreboard's consistency assertion.
package regfile_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_AW    = $clog2(DEF_NREGS);
    localparam int REG_ZERO  = 0;
    localparam int MAX_REGS  = 256;

    typedef logic [DEF_AW-1:0] regAddr_t;

    function automatic int popcount_busy(input logic [MAX_REGS-1:0] busyVec);
        int n;
        n = 0;
        for (int i = 0; i < MAX_REGS; i++) begin
            n += int'(busyVec[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/register_file_sb_if.sv
// Decode/writeback bus of the register file: read ports, write port, reservation port.
// Latency: reads/rsv_ok combinational; backpressure: rejected reservation (rsv_ok=0) means decode retries.
interface register_file_sb_if import regfile_pkg::*; #(
    parameter int XLEN = DEF_XLEN,
    parameter int AW   = DEF_AW,
    parameter int NRD  = 2
);
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic                rsv_ok;
    logic [AW:0]         busy_cnt;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rd_data, rd_busy, rsv_ok, busy_cnt
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rd_data, rd_busy, rsv_ok, busy_cnt
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register, write clears, accepted reservation sets.
// Latency: rsvOk combinational from registered busy bits; backpressure: busy target rejects (rsvOk=0).
module regfile_scoreboard import regfile_pkg::*; #(
    parameter int NREGS = DEF_NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wrEn,
    input  logic [AW-1:0]    wrAddr,
    input  logic             rsvEn,
    input  logic [AW-1:0]    rsvAddr,
    output logic             rsvOk,
    output logic [NREGS-1:0] busy,
    output logic [AW:0]      busyCnt
);

    logic [NREGS-1:0] busyQ;
    logic [NREGS-1:0] busyD;
    logic             wrClr;
    logic             clrHit;

    assign wrClr  = wrEn && (wrAddr != AW'(REG_ZERO));
    assign clrHit = wrClr && busyQ[wrAddr];
    assign rsvOk  = rsvEn && (rsvAddr != AW'(REG_ZERO)) && !busyQ[rsvAddr];
    assign busy   = busyQ;

    // Clear first, then set: a same-register pair only sets when the bit was free before the edge.
    always_comb begin
        busyD = busyQ;
        if (wrClr) busyD[wrAddr] = 1'b0;
        if (rsvOk) busyD[rsvAddr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busyQ   <= '0;
            busyCnt <= '0;
        end else begin
            busyQ   <= busyD;
            busyCnt <= busyCnt + (AW+1)'(rsvOk) - (AW+1)'(clrHit);
        end
    end

    cntMatchesBits: assert property (@(posedge clk) disable iff (!rst_n)
        int'(busyCnt) == popcount_busy(MAX_REGS'(busyQ)));

endmodule

// File: rtl/register_file_sb.sv
// Parametrised register file (x0 = 0, SP preset on reset) with write bypass and busy scoreboard.
// Latency: zero-cycle reads, writes visible next cycle (same cycle with BYPASS); backpressure: rsv_ok=0 stalls decode.
module register_file_sb import regfile_pkg::*; #(
    parameter int XLEN    = DEF_XLEN,
    parameter int NREGS   = DEF_NREGS,
    parameter int AW      = $clog2(NREGS),
    parameter int NRD     = 2,
    parameter int BYPASS  = 1,
    parameter int SP_IDX  = 2,
    parameter int SP_INIT = 252
) (
    input  logic               clk,
    input  logic               rst_n,
    register_file_sb_if.slave  bus
);

    logic [XLEN-1:0]     regs [NREGS];
    logic [NREGS-1:0]    busyVec;
    logic [NRD*XLEN-1:0] rdDataV;
    logic [NRD-1:0]      rdBusyV;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= (i == SP_IDX) ? XLEN'(SP_INIT) : '0;
            end
        end else if (bus.wr_en && (bus.wr_addr != AW'(REG_ZERO))) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrEn    (bus.wr_en),
        .wrAddr  (bus.wr_addr),
        .rsvEn   (bus.rsv_en),
        .rsvAddr (bus.rsv_addr),
        .rsvOk   (bus.rsv_ok),
        .busy    (busyVec),
        .busyCnt (bus.busy_cnt)
    );

    // A forwarded write also retires the producer, so the port sees the register as not busy.
    always_comb begin
        logic [AW-1:0] ra;
        logic          fwd;
        rdDataV = '0;
        rdBusyV = '0;
        ra      = '0;
        fwd     = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            ra  = bus.rd_addr[p*AW +: AW];
            fwd = (BYPASS != 0) && bus.wr_en && (bus.wr_addr == ra);
            if (ra == AW'(REG_ZERO)) begin
                rdDataV[p*XLEN +: XLEN] = '0;
                rdBusyV[p]              = 1'b0;
            end else if (fwd) begin
                rdDataV[p*XLEN +: XLEN] = bus.wr_data;
                rdBusyV[p]              = 1'b0;
            end else begin
                rdDataV[p*XLEN +: XLEN] = regs[ra];
                rdBusyV[p]              = busyVec[ra];
            end
        end
    end

    assign bus.rd_data = rdDataV;
    assign bus.rd_busy = rdBusyV;

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: directed literal checks pin the plan, then random traffic vs an array model.
module tb_register_file_sb;
    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int AW = 5;
    localparam int NRD = 2;
    localparam int BYP = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   nCmp = 0;
    int   nFail = 0;
    bit   checkEn = 1'b0;

    always #5 clk = ~clk;

    register_file_sb_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD)) bus ();

    register_file_sb #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(BYP), .SP_IDX(2), .SP_INIT(252)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: architectural contents and reservation state as plain arrays.
    logic [XLEN-1:0] mMem [NREGS];
    bit              mBusy [NREGS];

    always @(posedge clk or negedge rst_n) begin
        bit ok;
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mMem[i]  = '0;
                mBusy[i] = 1'b0;
            end
            mMem[2] = 32'd252;
        end else begin
            ok = bus.rsv_en && (bus.rsv_addr != 0) && !mBusy[bus.rsv_addr];
            if (bus.wr_en && bus.wr_addr != 0) begin
                mMem[bus.wr_addr]  = bus.wr_data;
                mBusy[bus.wr_addr] = 1'b0;
            end
            if (ok) mBusy[bus.rsv_addr] = 1'b1;
        end
    end

    function automatic logic [XLEN-1:0] expData(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (BYP != 0 && bus.wr_en && bus.wr_addr == a) return bus.wr_data;
        return mMem[a];
    endfunction

    function automatic logic expBusy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        if (BYP != 0 && bus.wr_en && bus.wr_addr == a) return 1'b0;
        return mBusy[a];
    endfunction

    function automatic int expCnt();
        int n = 0;
        for (int i = 0; i < NREGS; i++) if (mBusy[i]) n++;
        return n;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Single compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (checkEn && rst_n) begin
            for (int p = 0; p < NRD; p++) begin
                chk($sformatf("rd_data%0d", p), 64'(bus.rd_data[p*XLEN +: XLEN]),
                    64'(expData(bus.rd_addr[p*AW +: AW])));
                chk($sformatf("rd_busy%0d", p), 64'(bus.rd_busy[p]),
                    64'(expBusy(bus.rd_addr[p*AW +: AW])));
            end
            chk("rsv_ok", 64'(bus.rsv_ok),
                64'(bus.rsv_en && bus.rsv_addr != 0 && !mBusy[bus.rsv_addr]));
            chk("busy_cnt", 64'(bus.busy_cnt), 64'(expCnt()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en  = 1'b0;
        bus.rsv_en = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rd_addr  = '0;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rsv_en   = 1'b0;
        bus.rsv_addr = '0;

        // 1: asynchronous assert and mid-cycle release
        #2 rst_n = 1'b0;
        #5 rst_n = 1'b1;
        #1;
        chk("reset busy_cnt", 64'(bus.busy_cnt), 64'd0);
        for (int i = 0; i < NREGS; i++) begin
            bus.rd_addr[AW-1:0] = AW'(i);
            #1;
            chk($sformatf("reset reg%0d", i), 64'(bus.rd_data[XLEN-1:0]), (i == 2) ? 64'd252 : 64'd0);
            chk($sformatf("reset busy%0d", i), 64'(bus.rd_busy[0]), 64'd0);
        end
        checkEn = 1'b1;

        // 2: write with same-cycle read of the target
        step();
        bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hDEADBEEF; bus.rd_addr[AW-1:0] = 5'd5;
        #2 chk("bypass same cycle", 64'(bus.rd_data[XLEN-1:0]), 64'hDEADBEEF);
        step(); idle();
        #2 chk("written value next cycle", 64'(bus.rd_data[XLEN-1:0]), 64'hDEADBEEF);

        // 3: x0 write discarded, x0 reservation rejected
        step();
        bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'h1234; bus.rd_addr[AW-1:0] = 5'd0;
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd0;
        #2 chk("x0 read during write", 64'(bus.rd_data[XLEN-1:0]), 64'd0);
        chk("x0 rsv_ok", 64'(bus.rsv_ok), 64'd0);
        step(); idle();
        #2 chk("x0 read after write", 64'(bus.rd_data[XLEN-1:0]), 64'd0);
        chk("x0 rsv busy_cnt", 64'(bus.busy_cnt), 64'd0);

        // 4: reserve, WAW reject, retire by write
        step();
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd7; bus.rd_addr[2*AW-1:AW] = 5'd7;
        #2 chk("rsv7 ok", 64'(bus.rsv_ok), 64'd1);
        step();
        #2 chk("rsv7 again ok", 64'(bus.rsv_ok), 64'd0);
        chk("rsv7 busy_cnt", 64'(bus.busy_cnt), 64'd1);
        chk("rsv7 rd_busy1", 64'(bus.rd_busy[1]), 64'd1);
        step(); idle();
        bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h55;
        #2 chk("wr7 bypass busy", 64'(bus.rd_busy[1]), 64'd0);
        step(); idle();
        #2 chk("wr7 busy_cnt", 64'(bus.busy_cnt), 64'd0);
        chk("wr7 rd_busy1", 64'(bus.rd_busy[1]), 64'd0);
        chk("wr7 rd_data1", 64'(bus.rd_data[2*XLEN-1:XLEN]), 64'h55);

        // 5: same-cycle write + reservation of one register, busy then free
        step();
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd9; bus.rd_addr[2*AW-1:AW] = 5'd9;
        #2 chk("rsv9 ok", 64'(bus.rsv_ok), 64'd1);
        step();
        bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h99;
        #2 chk("wr+rsv9 busy ok", 64'(bus.rsv_ok), 64'd0);
        chk("wr+rsv9 busy cnt", 64'(bus.busy_cnt), 64'd1);
        step(); idle();
        #2 chk("after pair busy9", 64'(bus.rd_busy[1]), 64'd0);
        chk("after pair cnt", 64'(bus.busy_cnt), 64'd0);
        step();
        bus.wr_en = 1'b1; bus.rsv_en = 1'b1;
        #2 chk("wr+rsv9 free ok", 64'(bus.rsv_ok), 64'd1);
        step(); idle();
        #2 chk("after free pair busy9", 64'(bus.rd_busy[1]), 64'd1);
        chk("after free pair cnt", 64'(bus.busy_cnt), 64'd1);

        // 6: net-zero count change, then async reset with busy bits set
        step();
        bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3;
        step(); idle();
        #2 chk("only 3 busy", 64'(bus.busy_cnt), 64'd1);
        step();
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd4; bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'h33;
        #2 chk("rsv4 ok", 64'(bus.rsv_ok), 64'd1);
        step(); idle();
        bus.rd_addr[AW-1:0] = 5'd4; bus.rd_addr[2*AW-1:AW] = 5'd2;
        #2 chk("net zero cnt", 64'(bus.busy_cnt), 64'd1);
        chk("rd_busy4", 64'(bus.rd_busy[0]), 64'd1);
        #1 rst_n = 1'b0;
        #1 chk("async rst cnt", 64'(bus.busy_cnt), 64'd0);
        chk("async rst rd_busy", 64'(bus.rd_busy), 64'd0);
        chk("async rst reg4", 64'(bus.rd_data[XLEN-1:0]), 64'd0);
        chk("async rst sp", 64'(bus.rd_data[2*XLEN-1:XLEN]), 64'd252);
        #3 rst_n = 1'b1;

        // Random traffic, biased to a few registers to provoke collisions.
        for (int c = 0; c < 3000; c++) begin
            step();
            if (c == 1500) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            for (int p = 0; p < NRD; p++)
                bus.rd_addr[p*AW +: AW] = AW'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, NREGS-1));
            bus.wr_en    = ($urandom_range(0, 2) == 0);
            bus.wr_addr  = AW'($urandom_range(0, 7));
            bus.wr_data  = $urandom;
            bus.rsv_en   = ($urandom_range(0, 1) == 1);
            bus.rsv_addr = AW'($urandom_range(0, 3) == 0 ? $urandom_range(0, NREGS-1) : $urandom_range(0, 7));
        end
        step(); idle();
        @(posedge clk);
        #1;
        checkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end
endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- Parametrised successor to the datapath's single-bank 32x32 register file.
- Adds a configurable register width, register count and number of read ports, plus an optional write-to-read bypass and an integrated busy-bit scoreboard for multi-cycle producers such as loads and multiply/divide.
- Sits between decode (read ports, reservations) and writeback (write port) in the RISC-V datapath.
- Register x0 is hardwired to zero. The stack-pointer preset value is applied on reset.

Parameters:
XLEN, 32, register width in bits
NREGS, 32, number of architectural registers (power of two, at least 2)
AW, $clog2(NREGS), register address width (derived, do not override)
NRD, 2, number of read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = read returns old value
SP_IDX, 2, index of the register preset on reset (stack pointer)
SP_INIT, 252, reset value of register SP_IDX

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
rd_addr  in  NRD*AW  packed read addresses; port i uses bits [i*AW +: AW]
rd_data  out  NRD*XLEN  packed read data; port i uses bits [i*XLEN +: XLEN]
rd_busy  out  NRD  read port i addresses a register with a pending reservation
wr_en  in  1  writeback enable
wr_addr  in  AW  writeback destination register
wr_data  in  XLEN  writeback data
rsv_en  in  1  reservation request: mark rsv_addr busy
rsv_addr  in  AW  register to reserve
rsv_ok  out  1  reservation accepted this cycle
busy_cnt  out  AW+1  number of registers currently marked busy

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers cleared to 0, except register SP_IDX, which is loaded with SP_INIT.
  - All busy bits cleared; busy_cnt = 0.
  - On release, the first state-changing edge is the first rising clk edge with rst_n high.
- Reads are combinational and have zero latency.
  - rd_data_i = reg[rd_addr_i]; reading address 0 always returns 0.
  - BYPASS=1: if wr_en, wr_addr == rd_addr_i and wr_addr != 0, then rd_data_i = wr_data in the same cycle.
  - BYPASS=0: the read returns the pre-write value; the new value is visible from the next cycle.
- Write:
  - On a rising edge with wr_en=1 and wr_addr != 0, reg[wr_addr] <= wr_data.
  - wr_addr = 0 is discarded silently.
- Scoreboard, with one busy bit per register (bit 0 is constant 0):
  - rsv_ok = rsv_en & (rsv_addr != 0) & ~busy[rsv_addr], where busy is the registered value.
  - Accepted reservation: busy[rsv_addr] <= 1 at the edge.
  - Rejected reservation (target already busy, i.e. a WAW hazard): no state change. Decode must stall and retry.
  - Reserving x0: rsv_ok = 0 and nothing changes. Decode must not request it.
  - Write to a nonzero wr_addr: busy[wr_addr] <= 0 at the edge, whether or not the register was reserved.
  - Simultaneous write and reservation to the same register:
    - The write's clear is applied first, then the reservation's set is evaluated against the pre-edge busy value.
    - If the register was busy, rsv_ok = 0 and the result is busy=0 (the write retires the old producer).
    - If the register was free, rsv_ok = 1 and the result is busy=1.
- rd_busy_i = busy[rd_addr_i], except when BYPASS=1 and this cycle's write targets rd_addr_i, in which case rd_busy_i = 0.
  - rd_busy_i is 0 for address 0.
- busy_cnt is a registered counter, updated on the same edge as the busy bits, and always equals the popcount of the busy bits.
  - Counter update is +1 on an accepted reservation and −1 on a write that clears a set bit.
  - An accepted reservation and a clear of a different set bit in the same cycle give a net change of 0.
- There is no error output. Out-of-range addresses cannot occur because NREGS is a power of two.

Decomposition:
- Package regfile_pkg holds:
  - the default XLEN, NREGS and the x0 index constant (REG_ZERO = 0);
  - a typedef for the register address (logic [AW-1:0]);
  - function popcount_busy, used only by assertions.
- One sub-module is natural: regfile_scoreboard.
  - It owns the busy bits, rsv_ok, busy_cnt and the write-clear/reserve-set arbitration.
- The top level keeps the storage array, the read multiplexers and the bypass logic.

Test Plan:
1. Assert and release rst_n mid-cycle (asynchronously) → all reads return 0 except reg[2] = 252; busy_cnt = 0; rd_busy = 0.
2. Write wr_addr=5, wr_data=0xDEADBEEF while port0 reads 5 in the same cycle:
   - BYPASS=1 → rd_data0 = 0xDEADBEEF that cycle.
   - BYPASS=0 → old value 0 that cycle, 0xDEADBEEF the next cycle.
3. Write wr_addr=0, wr_data=0x1234, then read 0 → rd_data = 0. Also reserve rsv_addr=0 → rsv_ok = 0 and busy_cnt unchanged.
4. Reserve 7 → rsv_ok=1, busy_cnt=1, port1 reading 7 shows rd_busy=1.
   - Reserve 7 again → rsv_ok=0, busy_cnt=1.
   - Write 7=0x55 → next cycle busy_cnt=0, rd_busy=0, rd_data=0x55.
5. With 9 busy, issue a same-cycle write to 9 and reservation of 9 → rsv_ok=0 and busy[9]=0 after the edge.
   - With 9 free, the same pair → rsv_ok=1 and busy[9]=1; busy_cnt tracks the popcount throughout.
6. With 3 busy, reserve 4 while writing 3 → busy_cnt stays at 1 (net 0). Then assert rst_n low with busy bits set → busy_cnt and all rd_busy go to 0 immediately, without waiting for a clock edge.
